busca_instrucao: RTL

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 134 +++++++++++++
 1 files changed

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: streams words from a synchronous instruction memory,
// handles redirects, stalls and halt. Define FETCH_COUNT_EN to add the instrCount port.
module busca_instrucao #(
    parameter int unsigned SIZE        = 500,
    parameter logic [5:0]  HALT_OPCODE = 6'b010111
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] endInstr,
    input  logic [31:0] pcInstr,
    input  logic [31:0] posMem,
    input  logic        jumpEn,
    input  logic [31:0] jumpAddr,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    output logic        halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] instrCount
`endif
);

    localparam logic [31:0] LAST_ADDR = 32'(SIZE - 1);
    localparam logic [31:0] ADDR_LIM  = 32'(SIZE);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_expPc;
    logic [31:0] r_instr;
    logic [31:0] r_instrPc;
    logic        r_valid;
    logic        r_halted;

    logic        w_run;
    logic        w_jump;
    logic        w_jumpOk;
    logic        w_match;
    logic        w_ready;
    logic        w_capture;
    logic        w_isHalt;
    logic [31:0] w_nextPc;

    assign w_run     = (r_state == ST_RUN);
    assign w_jump    = w_run && jumpEn;
    assign w_jumpOk  = (jumpAddr < ADDR_LIM);
    assign w_match   = (posMem == r_expPc);
    assign w_ready   = !r_valid || !stall;
    // A redirect takes priority: the word arriving this cycle belongs to the old path.
    assign w_capture = w_run && w_match && w_ready && !jumpEn;
    assign w_isHalt  = (pcInstr[31:26] == HALT_OPCODE);
    assign w_nextPc  = (r_expPc == LAST_ADDR) ? 32'd0 : r_expPc + 32'd1;

    // Address issued now is answered next cycle, so streaming asks for the word after the one captured.
    always_comb begin
        endInstr = r_expPc;
        if (w_jump && w_jumpOk) begin
            endInstr = jumpAddr;
        end else if (w_capture) begin
            endInstr = w_nextPc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_BOOT;
            r_expPc   <= 32'd0;
            r_instr   <= 32'd0;
            r_instrPc <= 32'd0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_jump) begin
                        r_valid <= 1'b0;
                        if (w_jumpOk) begin
                            r_expPc <= jumpAddr;
                        end else begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end else if (w_capture) begin
                        r_instr   <= pcInstr;
                        r_instrPc <= posMem;
                        r_valid   <= 1'b1;
                        r_expPc   <= w_nextPc;
                        if (w_isHalt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end else begin
                        r_valid <= r_valid && stall;
                    end
                end
                ST_HALT: begin
                    r_valid <= r_valid && stall;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (w_capture) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign instrCount = r_count;
`endif

    assign instr      = r_instr;
    assign instrPc    = r_instrPc;
    assign instrValid = r_valid;
    assign halted     = r_halted;

endmodule
